// File: rtl/right_barrel_shifter_if.sv
// Operand/result bundle for the registered right barrel shifter.
// RIGHT_BARREL_SHIFTER_ROTATE_EN adds the ctrl_rotate control line.
interface right_barrel_shifter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   in_valid;
    logic [DATA_WIDTH-1:0]  data_operandA;
    logic [SHAMT_WIDTH-1:0] ctrl_shiftamt;
    logic                   ctrl_arith;
    logic [DATA_WIDTH-1:0]  data_result;
    logic                   out_valid;
`ifdef RIGHT_BARREL_SHIFTER_ROTATE_EN
    logic                   ctrl_rotate;

    modport master (
        output in_valid, data_operandA, ctrl_shiftamt,
        output ctrl_arith, ctrl_rotate,
        input  data_result, out_valid
    );
    modport slave (
        input  in_valid, data_operandA, ctrl_shiftamt,
        input  ctrl_arith, ctrl_rotate,
        output data_result, out_valid
    );
`else
    modport master (
        output in_valid, data_operandA, ctrl_shiftamt, ctrl_arith,
        input  data_result, out_valid
    );
    modport slave (
        input  in_valid, data_operandA, ctrl_shiftamt, ctrl_arith,
        output data_result, out_valid
    );
`endif
endinterface

// File: rtl/right_barrel_shifter.sv
// Registered 32-bit right barrel shifter (logical/arithmetic) for MultDiv.
// RIGHT_BARREL_SHIFTER_ROTATE_EN adds rotate-right via ctrl_rotate.
module right_barrel_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    right_barrel_shifter_if.slave bus
);
    logic [SHAMT_WIDTH-1:0] amt;
    logic                   fill;
    logic                   rot;
    logic [DATA_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0]  result_q;
    logic                   valid_q;

    assign amt  = bus.ctrl_shiftamt;
    assign fill = bus.ctrl_arith & bus.data_operandA[DATA_WIDTH-1];

`ifdef RIGHT_BARREL_SHIFTER_ROTATE_EN
    assign rot = bus.ctrl_rotate;
`else
    assign rot = 1'b0;
`endif

    // Each stage inserts either the fill bit or the bits it pushed out.
    always_comb begin
        shifted = bus.data_operandA;
        if (amt[4])
            shifted = {rot ? shifted[15:0] : {16{fill}},
                       shifted[DATA_WIDTH-1:16]};
        if (amt[3])
            shifted = {rot ? shifted[7:0] : {8{fill}},
                       shifted[DATA_WIDTH-1:8]};
        if (amt[2])
            shifted = {rot ? shifted[3:0] : {4{fill}},
                       shifted[DATA_WIDTH-1:4]};
        if (amt[1])
            shifted = {rot ? shifted[1:0] : {2{fill}},
                       shifted[DATA_WIDTH-1:2]};
        if (amt[0])
            shifted = {rot ? shifted[0] : fill,
                       shifted[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid)
                result_q <= shifted;
        end
    end

    assign bus.data_result = result_q;
    assign bus.out_valid   = valid_q;
endmodule

// File: tb/tb_right_barrel_shifter.sv
// Scoreboard bench for right_barrel_shifter: expected results are queued
// at drive time and compared one cycle later.
module tb_right_barrel_shifter;
    typedef struct {
        logic [31:0] res;
        logic        vld;
    } exp_t;

    logic        clock;
    logic        reset_n;
    exp_t        sb[$];
    logic [31:0] held;
    int          n_checks;
    int          n_fail;

    right_barrel_shifter_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();

    right_barrel_shifter #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [31:0] a, input int n,
                                          input logic arith, input logic rot);
        logic [31:0] r;
        if (rot)
            r = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
        else if (arith)
            r = $signed(a) >>> n;
        else
            r = a >> n;
        return r;
    endfunction

    task automatic apply(input logic [31:0] a, input int n, input logic arith,
                         input logic rot, input logic vld, input logic [31:0] exp_res);
        exp_t e;
        bus.in_valid      = vld;
        bus.data_operandA = a;
        bus.ctrl_shiftamt = n[4:0];
        bus.ctrl_arith    = arith;
`ifdef RIGHT_BARREL_SHIFTER_ROTATE_EN
        bus.ctrl_rotate   = rot;
`endif
        if (vld)
            held = exp_res;
        e.res = held;
        e.vld = vld;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        bus.in_valid      = 1'b1;
        bus.data_operandA = 32'hFFFFFFFF;
        bus.ctrl_shiftamt = 5'd0;
        bus.ctrl_arith    = 1'b0;
`ifdef RIGHT_BARREL_SHIFTER_ROTATE_EN
        bus.ctrl_rotate   = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            n_checks++;
            if (bus.data_result !== 32'h0 || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h/%b want 00000000/0",
                         i, bus.data_result, bus.out_valid);
            end
        end
        held    = 32'h0;
        reset_n = 1'b1;
        apply(32'h12345678, 8, 1'b0, 1'b0, 1'b1, 32'h00123456);
        @(posedge clock); #1;
        begin
            exp_t e = sb.pop_front();
            n_checks++;
            if (bus.data_result !== e.res || bus.out_valid !== e.vld) begin
                n_fail++;
                $display("FAIL first_after_reset: got %h/%b want %h/%b",
                         bus.data_result, bus.out_valid, e.res, e.vld);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] a_t[6]   = '{32'h80000000, 32'h80000000, 32'h80000000,
                                  32'h80000000, 32'h80000000, 32'h7FFFFFFF};
        int          n_t[6]   = '{0, 2, 2, 31, 31, 31};
        logic        ar_t[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ex_t[6]  = '{32'h80000000, 32'h20000000, 32'hE0000000,
                                  32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            apply(a_t[i], n_t[i], ar_t[i], 1'b0, 1'b1, ex_t[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            n_checks++;
            if (bus.data_result !== e.res || bus.out_valid !== e.vld) begin
                n_fail++;
                $display("FAIL directed[%0d]: got %h/%b want %h/%b",
                         i, bus.data_result, bus.out_valid, e.res, e.vld);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        v_t[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        int          n_t[4]  = '{4, 16, 0, 3};
        logic [31:0] ex_t[4] = '{32'h01234567, 32'h00001234,
                                 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            apply(32'h12345678, n_t[i], 1'b0, 1'b0, v_t[i], ex_t[i]);
            @(posedge clock); #1;
            e = sb.pop_front();
            n_checks++;
            if (bus.data_result !== e.res || bus.out_valid !== e.vld) begin
                n_fail++;
                $display("FAIL stream_hold[%0d]: got %h/%b want %h/%b",
                         i, bus.data_result, bus.out_valid, e.res, e.vld);
            end
        end
    endtask

    task automatic test_reset_midstream();
        apply(32'hCAFEF00D, 4, 1'b1, 1'b0, 1'b1, 32'hFCAFEF00);
        @(posedge clock); #1;
        void'(sb.pop_front());
        apply(32'hDEADBEEF, 1, 1'b0, 1'b0, 1'b1, 32'h6F56DF77);
        reset_n = 1'b0;
        @(posedge clock); #1;
        void'(sb.pop_front());
        n_checks++;
        if (bus.data_result !== 32'h0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midstream: got %h/%b want 00000000/0",
                     bus.data_result, bus.out_valid);
        end
        reset_n = 1'b1;
        held    = 32'h0;
    endtask

    task automatic test_random(input int modes);
        for (int m = 0; m < modes; m++) begin
            for (int n = 0; n < 32; n++) begin
                logic [31:0] a;
                exp_t        e;
                logic        ar = (m == 1);
                logic        ro = (m == 2);
                a = $urandom;
                if (n[0]) a[31] = 1'b1;
                apply(a, n, ar, ro, 1'b1, model(a, n, ar, ro));
                @(posedge clock); #1;
                e = sb.pop_front();
                n_checks++;
                if (bus.data_result !== e.res || bus.out_valid !== e.vld) begin
                    n_fail++;
                    $display("FAIL random m%0d n%0d a=%h: got %h/%b want %h/%b",
                             m, n, a, bus.data_result, bus.out_valid, e.res, e.vld);
                end
            end
        end
    endtask

`ifdef RIGHT_BARREL_SHIFTER_ROTATE_EN
    task automatic test_rotate();
        exp_t e;
        apply(32'h80000001, 1, 1'b1, 1'b1, 1'b1, 32'hC0000000);
        @(posedge clock); #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.data_result !== e.res || bus.out_valid !== e.vld) begin
            n_fail++;
            $display("FAIL rotate: got %h/%b want %h/%b",
                     bus.data_result, bus.out_valid, e.res, e.vld);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        held     = 32'h0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
`ifdef RIGHT_BARREL_SHIFTER_ROTATE_EN
        test_rotate();
        test_random(3);
`else
        test_random(2);
`endif
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/right_barrel_shifter.md
Name: right_barrel_shifter

Overview:
- Registered 32-bit right barrel shifter for the MultDiv datapath.
- Shifts data_operandA right by 0-31 places in a single cycle, either logical (zero fill) or arithmetic (sign fill).
- Built as five cascaded mux stages of 16, 8, 4, 2 and 1 places, followed by one output register with a valid flag.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand/control qualifier; the inputs are captured on a clock edge when high.
- data_operandA  input  32  value to shift.
- ctrl_shiftamt  input  5  shift distance, 0-31.
- ctrl_arith  input  1  0 = logical shift (fill with 0); 1 = arithmetic shift (fill with data_operandA[31]).
- data_result  output  32  registered shift result.
- out_valid  output  1  high for one cycle per accepted input.

Behaviour:
- Reset: on a rising edge with reset_n=0, data_result <= 32'h0 and out_valid <= 0. Reset overrides in_valid on the same edge. Reset mid-stream discards the pending result.
- Datapath: fill = ctrl_arith & data_operandA[31]. Stage k (k = 4 down to 0): if ctrl_shiftamt[k] is set, shift right by 2^k, inserting fill in the vacated MSBs; otherwise pass through.
- Combinational result: logical = A >> n; arithmetic = signed A >>> n.
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear on data_result with out_valid=1 after edge N.
- Throughput: one operation per cycle. No backpressure and no ready signal.
- in_valid=0: out_valid <= 0 and data_result holds its previous value.
- Boundaries:
  - shiftamt=0 passes A through unchanged in both modes.
  - shiftamt=31, logical: result = {31'b0, A[31]}.
  - shiftamt=31, arithmetic: result = {32{A[31]}}.
  - Arithmetic shift of a non-negative A is identical to a logical shift.
- There is no internal state beyond the output register. Back-to-back operations are independent.

Optional Feature:
- Macro: RIGHT_BARREL_SHIFTER_ROTATE_EN.
- Defined:
  - Adds input port ctrl_rotate (1 bit).
  - When ctrl_rotate=1, each stage inserts the bits shifted out of the LSB end into the MSBs, giving a rotate right by ctrl_shiftamt.
  - ctrl_rotate takes priority over ctrl_arith.
  - Latency and reset behaviour are unchanged.
- Undefined:
  - The port is absent.
  - Only logical and arithmetic shifts are supported.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 and A=32'hFFFFFFFF -> data_result=32'h0, out_valid=0; first valid input after release appears one cycle later.
- Pass-through: A=32'h80000000, shamt=0, arith=0 -> 32'h80000000 one cycle later with out_valid=1.
- Logical vs arithmetic, A=32'h80000000, shamt=2:
  - arith=0 -> 32'h20000000.
  - arith=1 -> 32'hE0000000.
- Extremes:
  - A=32'h80000000, shamt=31, arith=0 -> 32'h00000001.
  - A=32'h80000000, shamt=31, arith=1 -> 32'hFFFFFFFF.
  - A=32'h7FFFFFFF, shamt=31, arith=1 -> 32'h0.
- Streaming and hold: back-to-back A=32'h12345678 with shamt=4 then shamt=16 (arith=0) -> 32'h01234567, then 32'h00001234 on consecutive cycles; then in_valid=0 -> out_valid=0 and data_result holds 32'h00001234.
- Rotate (macro defined): A=32'h80000001, shamt=1, ctrl_rotate=1 -> 32'hC0000000; exhaustive random compare of all 32 shift amounts against a reference model for each mode.
